// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// enable and mux select. Memory states wait on mem_ready with a bounded wait;
// on timeout mem_err pulses and the instruction is retried from FETCH.
// Outputs decode from the current state; pc_en and ir_write in FETCH are
// qualified by mem_ready and pc_en in BEQ_EX by alu_zero.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes lock into TRAP).
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       mem_err,
    output logic [3:0] state_o
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [CW-1:0]   r_waitCnt;
    logic            r_memErr;
    logic            w_memState;
    logic            w_timeout;
    logic            w_pcWrite;
    logic            w_branch;

    assign w_memState = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout  = w_memState && !mem_ready && (r_waitCnt == CW'(MEM_TIMEOUT - 1));

    // Next-state selection; a timed-out access always falls back to FETCH.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_nextState = S_DECODE;
                else if (w_timeout) w_nextState = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE: w_nextState = (funct == FN_JR) ? S_JR : S_RTYPE_EX;
                    OP_LW:    w_nextState = S_MEMADR;
                    OP_SW:    w_nextState = S_MEMADR;
                    OP_BEQ:   w_nextState = S_BEQ_EX;
                    OP_ADDI:  w_nextState = S_ADDI_EX;
                    OP_J:     w_nextState = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:  w_nextState = S_TRAP;
`else
                    default:  w_nextState = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_nextState = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)      w_nextState = S_MEMWB;
                else if (w_timeout) w_nextState = S_FETCH;
            end
            S_MEMWB:    w_nextState = S_FETCH;
            S_MEMWR: begin
                if (mem_ready || w_timeout) w_nextState = S_FETCH;
            end
            S_RTYPE_EX: w_nextState = S_RTYPE_WB;
            S_RTYPE_WB: w_nextState = S_FETCH;
            S_BEQ_EX:   w_nextState = S_FETCH;
            S_ADDI_EX:  w_nextState = S_ADDI_WB;
            S_ADDI_WB:  w_nextState = S_FETCH;
            S_JUMP:     w_nextState = S_FETCH;
            S_JR:       w_nextState = S_FETCH;
            S_TRAP:     w_nextState = S_TRAP;
            default:    w_nextState = S_FETCH;
        endcase
    end

    // State, memory wait counter and the registered timeout pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_waitCnt <= '0;
            r_memErr  <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_memErr <= w_timeout;
            if ((w_nextState != r_state) || w_timeout)
                r_waitCnt <= '0;
            else if (w_memState && !mem_ready)
                r_waitCnt <= r_waitCnt + CW'(1);
        end
    end

    // Datapath control decode from the current state.
    always_comb begin
        w_pcWrite  = 1'b0;
        w_branch   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                w_pcWrite = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RTYPE_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                w_branch  = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                w_pcWrite = 1'b1;
            end
            S_JR: begin
                pc_source = 2'b11;
                w_pcWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pc_en   = w_pcWrite | (w_branch & alu_zero);
    assign mem_err = r_memErr;
    assign state_o = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl.
// An instruction-level model (per-opcode state paths plus a per-state action
// table) predicts every output each cycle; directed sequences pin it with
// hand-computed state traces and control values.
module tb_mips_multicycle_ctrl;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       alu_zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_en, ir_write, iord, mem_read, mem_write, reg_write;
   logic       reg_dst, mem_to_reg, alu_src_a, mem_err;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state_o;

   int nCompared = 0;
   int nMismatched = 0;

   mips_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .alu_zero(alu_zero), .mem_ready(mem_ready), .pc_en(pc_en),
      .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_source(pc_source), .mem_err(mem_err),
      .state_o(state_o)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   // Per-state actions: {pcWrite, branch, irWrite, iord, memRead, memWrite,
   // regWrite, regDst, memToReg, srcA, srcB, aluOp, pcSource}
   typedef struct packed {
      logic pcw, br, irw, iord, mr, mw, rw, rd, m2r, sa;
      logic [1:0] sb, op, ps;
   } ctl_t;

   ctl_t actTable [16];
   int   mState = 0;
   int   mWait = 0;
   bit   mErr = 0;
   int   mPath [$];

   function automatic ctl_t mk(input logic pcw, br, irw, io, mr, mw, rw, rd, m2r, sa,
                               input logic [1:0] sb, op, ps);
      mk = '{pcw, br, irw, io, mr, mw, rw, rd, m2r, sa, sb, op, ps};
   endfunction

   // Action table, one row per architectural step
   initial begin
      for (int i = 0; i < 16; i++) actTable[i] = '0;
      actTable[0]  = mk(1,0,1,0,1,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
      actTable[1]  = mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
      actTable[2]  = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
      actTable[3]  = mk(0,0,0,1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
      actTable[4]  = mk(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00);
      actTable[5]  = mk(0,0,0,1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00);
      actTable[6]  = mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
      actTable[7]  = mk(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00);
      actTable[8]  = mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
      actTable[9]  = mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
      actTable[10] = mk(0,0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00);
      actTable[11] = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10);
      actTable[12] = mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b11);
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual != expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Model advance: walks the instruction's step list, with bounded memory waits
   always @(posedge clk) begin
      int  nxt;
      bit  err;
      bit  memStep;
      err = 0;
      if (reset) begin
         mState = 0; mWait = 0; mErr = 0; mPath.delete();
      end else begin
         memStep = (mState == 0) || (mState == 3) || (mState == 5);
         nxt = mState;
         if (mState == 15) begin
            nxt = 15;
         end else if (memStep) begin
            if (mem_ready) begin
               if (mState == 0) nxt = 1;
               else nxt = (mPath.size() > 0) ? mPath.pop_front() : 0;
            end else if (mWait == TO - 1) begin
               nxt = 0; err = 1; mPath.delete();
            end
         end else if (mState == 1) begin
            mPath.delete();
            if (opcode == 6'h00 && funct == 6'h08) mPath = {12};
            else if (opcode == 6'h00) mPath = {6, 7};
            else if (opcode == 6'h23) mPath = {2, 3, 4};
            else if (opcode == 6'h2B) mPath = {2, 5};
            else if (opcode == 6'h04) mPath = {8};
            else if (opcode == 6'h08) mPath = {9, 10};
            else if (opcode == 6'h02) mPath = {11};
            if (mPath.size() > 0) nxt = mPath.pop_front();
`ifdef ILLEGAL_TRAP_EN
            else nxt = 15;
`else
            else nxt = 0;
`endif
         end else begin
            nxt = (mPath.size() > 0) ? mPath.pop_front() : 0;
         end
         if (nxt != mState || err) mWait = 0;
         else if (memStep && !mem_ready) mWait++;
         mState = nxt;
         mErr = err;
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      ctl_t e;
      logic pcw, irw;
      if (!reset) begin
         e = actTable[mState];
         pcw = e.pcw;
         irw = e.irw;
         if (mState == 0 && !mem_ready) begin
            pcw = 1'b0;
            irw = 1'b0;
         end
         checkOutput("state_o", state_o, mState);
         checkOutput("pc_en", pc_en, int'(pcw | (e.br & alu_zero)));
         checkOutput("ir_write", ir_write, irw);
         checkOutput("iord", iord, e.iord);
         checkOutput("mem_read", mem_read, e.mr);
         checkOutput("mem_write", mem_write, e.mw);
         checkOutput("reg_write", reg_write, e.rw);
         checkOutput("reg_dst", reg_dst, e.rd);
         checkOutput("mem_to_reg", mem_to_reg, e.m2r);
         checkOutput("alu_src_a", alu_src_a, e.sa);
         checkOutput("alu_src_b", alu_src_b, e.sb);
         checkOutput("alu_op", alu_op, e.op);
         checkOutput("pc_source", pc_source, e.ps);
         checkOutput("mem_err", mem_err, mErr);
      end
   end

   logic [3:0] capState [64];
   logic [1:0] capPcSrc [64];
   logic       capRegWrite [64], capRegDst [64], capPcEn [64], capIrWrite [64];
   logic       capMemErr [64], capMemWrite [64], capMemToReg [64];

   // One cycle per entry: drive, sample at negedge, advance past posedge
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                                input logic [31:0] rdyBits, input int n);
      opcode = op;
      funct = fn;
      alu_zero = zero;
      for (int i = 0; i < n; i++) begin
         mem_ready = rdyBits[i];
         @(negedge clk);
         capState[i] = state_o;
         capPcSrc[i] = pc_source;
         capRegWrite[i] = reg_write;
         capRegDst[i] = reg_dst;
         capPcEn[i] = pc_en;
         capIrWrite[i] = ir_write;
         capMemErr[i] = mem_err;
         capMemWrite[i] = mem_write;
         capMemToReg[i] = mem_to_reg;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkStates(input string name, input logic [63:0] expNibbles, input int n);
      for (int i = 0; i < n; i++)
         checkOutput(name, capState[i], int'(expNibbles[i*4 +: 4]));
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput("reset.state", state_o, 0);
      checkOutput("reset.mem_read", mem_read, 1);
      checkOutput("reset.alu_src_b", alu_src_b, 1);
      checkOutput("reset.pc_en", pc_en, 0);
      checkOutput("reset.ir_write", ir_write, 0);
      checkOutput("reset.mem_err", mem_err, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rdyCount;
      int errCount;
      doReset();

      // FETCH timeout: 16 idle cycles, registered pulse on the 17th
      applyStimulus(6'h00, 6'h20, 1'b0, 32'h0, 18);
      errCount = 0;
      for (int i = 0; i < 18; i++) begin
         checkOutput("tofetch.state", capState[i], 0);
         checkOutput("tofetch.ir_write", capIrWrite[i], 0);
         checkOutput("tofetch.mem_err", capMemErr[i], (i == 16) ? 1 : 0);
      end

      // add
      applyStimulus(6'h00, 6'h20, 1'b0, 32'h0F, 5);
      checkStates("add.state", 64'h07610, 5);
      for (int i = 0; i < 5; i++) begin
         checkOutput("add.reg_write", capRegWrite[i], (i == 3) ? 1 : 0);
         checkOutput("add.reg_dst", capRegDst[i], (i == 3) ? 1 : 0);
      end

      // lw with three wait cycles in MEMRD
      applyStimulus(6'h23, 6'h00, 1'b0, 32'h41, 9);
      checkStates("lw.state", 64'h043333210, 9);
      rdyCount = 0;
      for (int i = 0; i < 9; i++) if (capState[i] == 4'd3) rdyCount++;
      checkOutput("lw.memrd_cycles", rdyCount, 4);
      checkOutput("lw.wb_reg_write", capRegWrite[7], 1);
      checkOutput("lw.wb_mem_to_reg", capMemToReg[7], 1);

      // beq taken then not taken
      applyStimulus(6'h04, 6'h00, 1'b1, 32'h1, 4);
      checkStates("beq1.state", 64'h0810, 4);
      checkOutput("beq1.pc_en", capPcEn[2], 1);
      checkOutput("beq1.pc_source", capPcSrc[2], 1);
      applyStimulus(6'h04, 6'h00, 1'b0, 32'h1, 4);
      checkStates("beq0.state", 64'h0810, 4);
      checkOutput("beq0.pc_en", capPcEn[2], 0);

      // jr
      applyStimulus(6'h00, 6'h08, 1'b0, 32'h1, 4);
      checkStates("jr.state", 64'h0C10, 4);
      checkOutput("jr.pc_source", capPcSrc[2], 3);
      checkOutput("jr.pc_en", capPcEn[2], 1);
      for (int i = 0; i < 4; i++) checkOutput("jr.reg_write", capRegWrite[i], 0);

      // j, sw, addi
      applyStimulus(6'h02, 6'h00, 1'b0, 32'h1, 4);
      checkStates("j.state", 64'h0B10, 4);
      checkOutput("j.pc_source", capPcSrc[2], 2);
      applyStimulus(6'h2B, 6'h00, 1'b0, 32'h9, 5);
      checkStates("sw.state", 64'h05210, 5);
      checkOutput("sw.mem_write", capMemWrite[3], 1);
      applyStimulus(6'h08, 6'h00, 1'b0, 32'h1, 5);
      checkStates("addi.state", 64'h0A910, 5);
      checkOutput("addi.reg_write", capRegWrite[3], 1);
      checkOutput("addi.reg_dst", capRegDst[3], 0);

      // sw whose write never completes: timeout in MEMWR
      applyStimulus(6'h2B, 6'h00, 1'b0, 32'h1, 20);
      checkOutput("towr.state_last_wait", capState[18], 5);
      checkOutput("towr.state_after", capState[19], 0);
      checkOutput("towr.mem_err", capMemErr[19], 1);
      checkOutput("towr.mem_err_early", capMemErr[18], 0);

      // illegal opcode
`ifdef ILLEGAL_TRAP_EN
      applyStimulus(6'h3F, 6'h00, 1'b0, 32'h1, 6);
      checkStates("illegal.state", 64'hFFFF10, 6);
      for (int i = 2; i < 6; i++) checkOutput("illegal.pc_en", capPcEn[i], 0);
`else
      applyStimulus(6'h3F, 6'h00, 1'b0, 32'h1, 3);
      checkStates("illegal.state", 64'h010, 3);
      checkOutput("illegal.pc_en", capPcEn[1], 0);
      checkOutput("illegal.reg_write", capRegWrite[1], 0);
`endif

      // reset in the middle of a write
      doReset();
      applyStimulus(6'h2B, 6'h00, 1'b0, 32'h1, 5);
      checkOutput("rstwr.in_memwr", capState[4], 5);
      reset = 1'b1;
      #1;
      checkOutput("rstwr.state", state_o, 0);
      checkOutput("rstwr.mem_write", mem_write, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(6'h2B, 6'h00, 1'b0, 32'h0, 2);
      checkStates("rstwr.after", 64'h00, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
